// File: rtl/byte_unstriping_pkg.sv
// Shared definitions for the byte striping / unstriping pair.
// Contents:
//   - K-symbol byte values used for packet framing and lane fill
//   - frame_state_t : framing FSM state type
//   - is_skp()      : identifies a SKP fill symbol (K=1, 8'h1C)
package byte_unstriping_pkg;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } frame_state_t;

    function automatic logic is_skp(input logic [7:0] sym, input logic sym_k);
        return sym_k && (sym == SKP);
    endfunction

endpackage

// File: rtl/frame_checker.sv
// Packet framing checker for the reassembled byte stream.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   sym, sym_k : byte and its K flag
//   strobe     : high in a cycle where sym/sym_k is transferred downstream
//   in_pkt     : high while inside a packet (STP/SDP seen, END/EDB not yet)
//   frame_err  : one-cycle pulse, the cycle after an illegal K symbol
module frame_checker
    import byte_unstriping_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sym,
    input  logic       sym_k,
    input  logic       strobe,
    output logic       in_pkt,
    output logic       frame_err
);

    frame_state_t state;
    frame_state_t state_next;
    logic         err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        if (strobe && sym_k) begin
            case (sym)
                STP, SDP: begin
                    if (state == IDLE) state_next = PKT;
                    else               err_next   = 1'b1;
                end
                END, EDB: begin
                    if (state == PKT) state_next = IDLE;
                    else              err_next   = 1'b1;
                end
                COM, IDL: begin
                    state_next = state;
                end
                default: begin
                    err_next = 1'b1;
                end
            endcase
        end
    end

    assign in_pkt = (state == PKT);

endmodule

// File: rtl/byte_unstriping.sv
// Reassembles a LANES-byte striped word into a serial byte stream,
// lane 0 first, dropping SKP fill symbols and checking packet framing.
// Ports:
//   CLK, RESET        : clock and synchronous active-high reset
//   i_LANE, i_LANE_K  : striped word (lane n at [8n+7:8n]) and per-lane K flags
//   i_VALID, o_READY  : word handshake
//   D, DK, o_VALID    : registered serial byte, its K flag and valid
//   i_READY           : downstream accepts D this cycle
//   o_IN_PKT          : inside a packet
//   o_FRAME_ERR       : one-cycle framing violation pulse
module byte_unstriping
    import byte_unstriping_pkg::*;
#(
    parameter int unsigned LANES = 4
)
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [8*LANES-1:0] i_LANE,
    input  logic [LANES-1:0]   i_LANE_K,
    input  logic               i_VALID,
    output logic               o_READY,
    output logic [7:0]         D,
    output logic               DK,
    output logic               o_VALID,
    input  logic               i_READY,
    output logic               o_IN_PKT,
    output logic               o_FRAME_ERR
);

    localparam int unsigned      IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [LANES-1:0][7:0] lane_buf;
    logic [LANES-1:0]      k_buf;
    logic                  buf_full;
    logic                  ready_en;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_inc;

    logic       cur_skp;
    logic       byte_xfer;
    logic       consume;
    logic       last;
    logic       word_xfer;
    logic [7:0] next_sym;
    logic       next_k;
    logic       next_skp;

    // D/DK/o_VALID always show the byte at idx. The buffered byte, not the
    // output register, decides whether the current slot is a SKP drop.
    always_comb begin
        idx_inc   = idx + IDX_W'(1);
        cur_skp   = buf_full && is_skp(lane_buf[idx], k_buf[idx]);
        byte_xfer = o_VALID && i_READY;
        consume   = cur_skp || byte_xfer;
        last      = (idx == LAST_IDX);
        // ready_en holds o_READY low for the first cycle after reset.
        o_READY   = ready_en && !RESET && (!buf_full || (consume && last));
        word_xfer = i_VALID && o_READY;

        next_sym = lane_buf[idx_inc];
        next_k   = k_buf[idx_inc];
        if (word_xfer) begin
            next_sym = i_LANE[7:0];
            next_k   = i_LANE_K[0];
        end
        next_skp = is_skp(next_sym, next_k);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf_full <= 1'b0;
            ready_en <= 1'b0;
            idx      <= '0;
            D        <= '0;
            DK       <= 1'b0;
            o_VALID  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (word_xfer || (consume && !last)) begin
                if (word_xfer) begin
                    lane_buf <= i_LANE;
                    k_buf    <= i_LANE_K;
                    buf_full <= 1'b1;
                    idx      <= '0;
                end else begin
                    idx <= idx_inc;
                end
                o_VALID <= !next_skp;
                D       <= next_skp ? 8'h00 : next_sym;
                DK      <= next_skp ? 1'b0 : next_k;
            end else if (consume) begin
                buf_full <= 1'b0;
                o_VALID  <= 1'b0;
                D        <= '0;
                DK       <= 1'b0;
            end
        end
    end

    frame_checker u_frame_checker (
        .clk       (CLK),
        .reset     (RESET),
        .sym       (D),
        .sym_k     (DK),
        .strobe    (byte_xfer),
        .in_pkt    (o_IN_PKT),
        .frame_err (o_FRAME_ERR)
    );

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed self-checking bench for byte_unstriping (LANES = 4).
// Outputs are sampled 2 time units after the rising edge; inputs change
// 1 time unit after the rising edge.
module tb_byte_unstriping;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] i_LANE;
    logic [3:0]  i_LANE_K;
    logic        i_VALID;
    logic        o_READY;
    logic [7:0]  D;
    logic        DK;
    logic        o_VALID;
    logic        i_READY;
    logic        o_IN_PKT;
    logic        o_FRAME_ERR;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    byte_unstriping #(.LANES(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_LANE      (i_LANE),
        .i_LANE_K    (i_LANE_K),
        .i_VALID     (i_VALID),
        .o_READY     (o_READY),
        .D           (D),
        .DK          (DK),
        .o_VALID     (o_VALID),
        .i_READY     (i_READY),
        .o_IN_PKT    (o_IN_PKT),
        .o_FRAME_ERR (o_FRAME_ERR)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET    = 1'b1;
        i_VALID  = 1'b0;
        i_READY  = 1'b1;
        i_LANE   = '0;
        i_LANE_K = '0;
        tick();
        tick();
        #1;
        total++;
        if ({o_READY, o_VALID, DK, D, o_IN_PKT, o_FRAME_ERR} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0000",
                     {o_READY, o_VALID, DK, D, o_IN_PKT, o_FRAME_ERR});
        end
        RESET = 1'b0;
        #1;
        total++;
        if (o_READY !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_delay got=%b exp=0", o_READY);
        end
        tick();
        #1;
        total++;
        if (o_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise got=%b exp=1", o_READY);
        end
    endtask

    task automatic test_basic;
        logic [9:0] eo [5];
        logic [1:0] ef [5];
        eo = '{10'h3FB, 10'h3BC, 10'h3BC, 10'h3FD, 10'h000};
        ef = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
        i_LANE   = {8'hFD, 8'hBC, 8'hBC, 8'hFB};
        i_LANE_K = 4'hF;
        i_VALID  = 1'b1;
        #1;
        total++;
        if (o_READY !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready_empty got=%b exp=1", o_READY);
        end
        tick();
        i_VALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            #1;
            total++;
            if ({o_VALID, DK, D} !== eo[c]) begin
                bad++;
                $display("FAIL basic_out c=%0d got=%h exp=%h", c, {o_VALID, DK, D}, eo[c]);
            end
            total++;
            if ({o_IN_PKT, o_FRAME_ERR} !== ef[c]) begin
                bad++;
                $display("FAIL basic_flags c=%0d got=%b exp=%b", c, {o_IN_PKT, o_FRAME_ERR}, ef[c]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] eo [9];
        logic       er [9];
        eo = '{10'h211, 10'h222, 10'h233, 10'h244, 10'h255, 10'h266, 10'h277, 10'h288, 10'h000};
        er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        i_LANE   = {8'h44, 8'h33, 8'h22, 8'h11};
        i_LANE_K = 4'h0;
        i_VALID  = 1'b1;
        tick();
        i_LANE = {8'h88, 8'h77, 8'h66, 8'h55};
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            if (c == 4) i_VALID = 1'b0;
            #1;
            total++;
            if ({o_VALID, DK, D} !== eo[c]) begin
                bad++;
                $display("FAIL b2b_out c=%0d got=%h exp=%h", c, {o_VALID, DK, D}, eo[c]);
            end
            total++;
            if (o_READY !== er[c]) begin
                bad++;
                $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, o_READY, er[c]);
            end
        end
    endtask

    task automatic test_stall;
        logic [9:0] eo  [8];
        logic       rdy [8];
        eo  = '{10'h2AA, 10'h2BB, 10'h2CC, 10'h2CC, 10'h2CC, 10'h2CC, 10'h2DD, 10'h000};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        i_LANE   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        i_LANE_K = 4'h0;
        i_VALID  = 1'b1;
        tick();
        i_VALID = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            i_READY = rdy[c];
            #1;
            total++;
            if ({o_VALID, DK, D} !== eo[c]) begin
                bad++;
                $display("FAIL stall_out c=%0d got=%h exp=%h", c, {o_VALID, DK, D}, eo[c]);
            end
        end
        i_READY = 1'b1;
    endtask

    task automatic test_skp;
        logic [9:0] eo  [5];
        logic       rdy [5];
        logic       er  [5];
        eo  = '{10'h2A1, 10'h000, 10'h2A2, 10'h2A3, 10'h000};
        rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        er  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        i_LANE   = {8'hA3, 8'hA2, 8'h1C, 8'hA1};
        i_LANE_K = 4'b0010;
        i_VALID  = 1'b1;
        tick();
        i_VALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            i_READY = rdy[c];
            #1;
            total++;
            if ({o_VALID, DK, D} !== eo[c]) begin
                bad++;
                $display("FAIL skp_out c=%0d got=%h exp=%h", c, {o_VALID, DK, D}, eo[c]);
            end
            total++;
            if (o_READY !== er[c]) begin
                bad++;
                $display("FAIL skp_ready c=%0d got=%b exp=%b", c, o_READY, er[c]);
            end
        end
        i_READY = 1'b1;
    endtask

    task automatic test_frame_err;
        logic [9:0] eo [10];
        logic [1:0] ef [10];
        eo = '{10'h3FD, 10'h3FB, 10'h3FB, 10'h3BC, 10'h000,
               10'h3F7, 10'h3FE, 10'h37C, 10'h21C, 10'h000};
        ef = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        i_LANE   = {8'hBC, 8'hFB, 8'hFB, 8'hFD};
        i_LANE_K = 4'hF;
        i_VALID  = 1'b1;
        tick();
        i_VALID = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            if (c == 4) begin
                i_LANE   = {8'h1C, 8'h7C, 8'hFE, 8'hF7};
                i_LANE_K = 4'b0111;
                i_VALID  = 1'b1;
            end
            if (c == 5) i_VALID = 1'b0;
            #1;
            total++;
            if ({o_VALID, DK, D} !== eo[c]) begin
                bad++;
                $display("FAIL frame_out c=%0d got=%h exp=%h", c, {o_VALID, DK, D}, eo[c]);
            end
            total++;
            if ({o_IN_PKT, o_FRAME_ERR} !== ef[c]) begin
                bad++;
                $display("FAIL frame_flags c=%0d got=%b exp=%b", c, {o_IN_PKT, o_FRAME_ERR}, ef[c]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] eo [5];
        eo = '{10'h20A, 10'h20B, 10'h20C, 10'h20D, 10'h000};
        i_LANE   = {8'h04, 8'h03, 8'h02, 8'hFB};
        i_LANE_K = 4'b0001;
        i_VALID  = 1'b1;
        tick();
        i_VALID = 1'b0;
        tick();
        RESET = 1'b1;
        #1;
        total++;
        if ({o_VALID, DK, D, o_IN_PKT} !== 11'h405) begin
            bad++;
            $display("FAIL rmid_before got=%h exp=405", {o_VALID, DK, D, o_IN_PKT});
        end
        tick();
        RESET = 1'b0;
        #1;
        total++;
        if ({o_READY, o_VALID, DK, D, o_IN_PKT, o_FRAME_ERR} !== 13'h0) begin
            bad++;
            $display("FAIL rmid_cleared got=%h exp=0000",
                     {o_READY, o_VALID, DK, D, o_IN_PKT, o_FRAME_ERR});
        end
        tick();
        i_LANE   = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
        i_LANE_K = 4'h0;
        i_VALID  = 1'b1;
        #1;
        total++;
        if (o_READY !== 1'b1) begin
            bad++;
            $display("FAIL rmid_ready got=%b exp=1", o_READY);
        end
        tick();
        i_VALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            #1;
            total++;
            if ({o_VALID, DK, D} !== eo[c]) begin
                bad++;
                $display("FAIL rmid_out c=%0d got=%h exp=%h", c, {o_VALID, DK, D}, eo[c]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_skp();
        test_frame_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 Parameter LANES, default 4, SHALL set the lane count (1..16).
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  SHALL be a synchronous, active-high reset.
REQ-004 i_LANE  input  8*LANES  SHALL carry one byte per lane; lane n at bits [8n+7:8n].
REQ-005 i_LANE_K  input  LANES  SHALL flag each lane byte as a K-symbol (1) or data (0).
REQ-006 i_VALID  input  1  SHALL mark i_LANE/i_LANE_K as a valid striped word.
REQ-007 o_READY  output  1  SHALL indicate that a word can be accepted this cycle.
REQ-008 D  output  8  SHALL carry the reassembled serial byte.
REQ-009 DK  output  1  SHALL carry the K flag of D.
REQ-010 o_VALID  output  1  SHALL mark D/DK as valid.
REQ-011 i_READY  input  1  SHALL indicate that downstream accepts D this cycle.
REQ-012 o_IN_PKT  output  1  SHALL be high while the framing FSM is in PKT.
REQ-013 o_FRAME_ERR  output  1  SHALL pulse high for one cycle on a framing violation.

Function
REQ-014 A word transfer SHALL occur when i_VALID && o_READY; i_LANE, i_LANE_K SHALL be captured into a one-word holding buffer and the lane index reset to 0.
REQ-015 A byte transfer SHALL occur when o_VALID && i_READY; the lane index SHALL then advance by 1.
REQ-016 Bytes SHALL be emitted lane 0 first, ascending to lane LANES-1.
REQ-017 The first byte of a word SHALL appear on D in the cycle after its transfer (latency 1); D/DK/o_VALID SHALL be driven from registers only, with no combinational path from any input.
REQ-018 A buffered byte with K=1 and value 8'h1C (SKP) SHALL be dropped: o_VALID low, index advances in that cycle regardless of i_READY.
REQ-019 o_READY SHALL be high when the buffer is empty, or when the last lane is being consumed (byte transfer or SKP drop) this cycle, giving gap-free back-to-back words.
REQ-020 With i_READY low, D, DK and o_VALID SHALL hold unchanged.
REQ-021 When o_VALID is low, D SHALL be 8'h00 and DK 0.
REQ-022 Framing FSM states SHALL be IDLE and PKT, evaluated on each byte transfer with DK=1.
REQ-023 STP (8'hFB) or SDP (8'h5C): IDLE->PKT; in PKT, flag an error and remain in PKT.
REQ-024 END (8'hFD) or EDB (8'hFE): PKT->IDLE; in IDLE, flag an error and remain in IDLE.
REQ-025 COM (8'hBC), IDL (8'h7C) and any data byte SHALL not change state; any other K byte SHALL flag an error.
REQ-026 o_FRAME_ERR SHALL assert in the cycle after the offending byte transfer for exactly one cycle.

Reset
REQ-027 While RESET is high: buffer empty, index 0, FSM IDLE, o_READY 0, D 8'h00, DK 0, o_VALID 0, o_IN_PKT 0, o_FRAME_ERR 0.
REQ-028 RESET asserted mid-word SHALL discard the remaining buffered bytes; o_READY SHALL rise the cycle after RESET deasserts.

Structure
REQ-029 Symbol constants STP, SDP, END, EDB, COM, SKP and IDL, and the FSM state type, SHALL live in a shared package used by both byte_striping and byte_unstriping.
REQ-030 The framing FSM SHALL be a sub-module named frame_checker, taking the byte, K flag and transfer strobe and producing o_IN_PKT and o_FRAME_ERR.

Verification
REQ-031 LANES=4, word {END,COM,COM,STP} with K=1111 and i_READY=1 -> D = FB,BC,BC,FD on four consecutive cycles starting one cycle after transfer; o_IN_PKT high from after FB until after FD; no error.
REQ-032 Two back-to-back words with i_VALID held high and i_READY=1 -> 8 consecutive o_VALID cycles, with o_READY high on the 4th byte of the first word.
REQ-033 i_READY low for 3 cycles during byte 2 -> D holds lane-2 value for 3 cycles; no byte lost or duplicated.
REQ-034 Word with lane 1 = 1C, K=1 -> 3 bytes emitted, with one o_VALID-low cycle in place of lane 1.
REQ-035 END with K=1 while in IDLE -> o_FRAME_ERR one-cycle pulse; second STP while in PKT -> pulse, with o_IN_PKT remaining high.
REQ-036 RESET asserted after byte 1 of a word -> next cycle o_VALID 0, D 00, o_IN_PKT 0; the next word restarts at lane 0.
